// File: rtl/escape_codec_if.sv
// escape_codec_if: UART FIFO and debug TAP signals around the byte-stuffing codec.
interface escape_codec_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] data_rec_i;
    logic              rx_empty_i;
    logic              read_o;
    logic              tx_ready_i;
    logic [DATA_W-1:0] data_send_o;
    logic              write_o;
    logic              read_i;
    logic              cmd_rec_o;
    logic [DATA_W-1:0] data_rec_o;
    logic              rx_empty_o;
    logic              write_i;
    logic [DATA_W-1:0] data_send_i;
    logic              cmd_send_i;
    logic [DATA_W-1:0] cmd_i;
    logic              tx_ready_o;
    logic              err_clr_i;
    logic [1:0]        err_o;
    modport master (
        output data_rec_i, rx_empty_i, tx_ready_i, read_i, write_i, data_send_i, cmd_send_i, cmd_i, err_clr_i,
        input  read_o, data_send_o, write_o, cmd_rec_o, data_rec_o, rx_empty_o, tx_ready_o, err_o
    );
    modport slave (
        input  data_rec_i, rx_empty_i, tx_ready_i, read_i, write_i, data_send_i, cmd_send_i, cmd_i, err_clr_i,
        output read_o, data_send_o, write_o, cmd_rec_o, data_rec_o, rx_empty_o, tx_ready_o, err_o
    );
endinterface

// File: rtl/escape_codec.sv
// escape_codec: escape-sequence decoder with FWFT word queue (RX) and escaping encoder (TX).
module escape_codec #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] ESC      = 8'hB1,
    parameter int                RX_DEPTH = 4
) (
    input logic           clk_i,
    input logic           rst_ni,
    escape_codec_if.slave bus
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic {R_IDLE, R_ESC} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_FIRST, T_SECOND} tx_state_t;
    rx_state_t         rx_state;
    tx_state_t         tx_state;
    logic [DATA_W:0]   mem [RX_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              full, empty, push, pop_tap;
    logic [DATA_W:0]   head;
    logic [2*DATA_W-1:0] tx_sh;
    logic              tx_two;
    logic [1:0]        err, err_set;
    assign full    = count == CW'(RX_DEPTH);
    assign empty   = count == '0;
    assign bus.read_o = rst_ni & ~bus.rx_empty_i & ~full;
    // The leading ESC of a pair produces no word; the second symbol does.
    assign push    = bus.read_o & (rx_state == R_ESC | bus.data_rec_i != ESC);
    assign pop_tap = bus.read_i & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr];
    assign {bus.cmd_rec_o, bus.data_rec_o} = head;
    assign bus.rx_empty_o = empty;
    always_ff @(posedge clk_i)
        if (push) mem[wr_ptr] <= {rx_state == R_ESC && bus.data_rec_i != ESC, bus.data_rec_i};
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            rx_state <= R_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (bus.read_o) rx_state <= (rx_state == R_IDLE && bus.data_rec_i == ESC) ? R_ESC : R_IDLE;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop_tap) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop_tap);
        end
    assign bus.tx_ready_o  = tx_state == T_IDLE;
    assign bus.write_o     = tx_state != T_IDLE & bus.tx_ready_i;
    assign bus.data_send_o = tx_state == T_FIRST  ? tx_sh[2*DATA_W-1:DATA_W] :
                             tx_state == T_SECOND ? tx_sh[DATA_W-1:0] : '0;
    assign err_set = {bus.read_i & empty, tx_state == T_IDLE & bus.cmd_send_i & bus.cmd_i == ESC};
    assign bus.err_o = err;
    // Data X is loaded as {X, ESC}; only X==ESC needs the second symbol.
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            tx_state <= T_IDLE;
            tx_sh    <= '0;
            tx_two   <= 1'b0;
            err      <= '0;
        end else begin
            err <= (err & ~{2{bus.err_clr_i}}) | err_set;
            case (tx_state)
                T_IDLE:
                    if (bus.cmd_send_i) begin
                        if (bus.cmd_i != ESC) begin
                            tx_sh    <= {ESC, bus.cmd_i};
                            tx_two   <= 1'b1;
                            tx_state <= T_FIRST;
                        end
                    end else if (bus.write_i) begin
                        tx_sh    <= {bus.data_send_i, ESC};
                        tx_two   <= bus.data_send_i == ESC;
                        tx_state <= T_FIRST;
                    end
                T_FIRST:  if (bus.tx_ready_i) tx_state <= tx_two ? T_SECOND : T_IDLE;
                T_SECOND: if (bus.tx_ready_i) tx_state <= T_IDLE;
                default:  tx_state <= T_IDLE;
            endcase
        end
endmodule

// File: tb/tb_escape_codec.sv
// tb_escape_codec: table vectors, hand sequences and randomized traffic against a wire-encoding model.
module tb_escape_codec;
    localparam logic [7:0] ESC = 8'hB1;
    typedef struct {
        bit         cmd;
        logic [7:0] v;
        int         n;
        logic [7:0] s0, s1;
        logic [1:0] err;
    } tx_vec_t;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    escape_codec_if #(.DATA_W(8)) bus();
    escape_codec #(.DATA_W(8), .ESC(8'hB1), .RX_DEPTH(4)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
    int tests = 0, fails = 0;
    logic [7:0] uq[$], sent[$], exp_s[$];
    logic [8:0] got[$], exp_w[$];
    bit tap_auto = 0, tap_rnd = 0, rdy_rnd = 0, last_write;
    tx_vec_t tv[7];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic feed();
        bus.rx_empty_i = uq.size() == 0;
        bus.data_rec_i = uq.size() == 0 ? 8'h00 : uq[0];
    endtask

    // Sample mid-cycle, then advance to just after the next rising edge.
    task automatic tick();
        bit popped;
        @(negedge clk);
        if (tap_auto) bus.read_i = !bus.rx_empty_o && (!tap_rnd || $urandom_range(0, 1) == 1);
        #1;
        popped     = bus.read_o;
        last_write = bus.write_o;
        if (bus.write_o) sent.push_back(bus.data_send_o);
        if (bus.read_i && !bus.rx_empty_o) got.push_back({bus.cmd_rec_o, bus.data_rec_o});
        @(posedge clk);
        #1;
        if (popped && uq.size() > 0) void'(uq.pop_front());
        if (rdy_rnd) bus.tx_ready_i = 1'($urandom_range(0, 1));
        feed();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.tx_ready_o && n < 200) begin tick(); n++; end
        if (n >= 200) chk("tx_idle_timeout", 0, 1);
    endtask

    task automatic tx_req(bit cmd, bit both, logic [7:0] v, logic [7:0] d);
        wait_idle();
        bus.cmd_send_i  = cmd;
        bus.cmd_i       = v;
        bus.write_i     = !cmd || both;
        bus.data_send_i = d;
        tick();
        bus.cmd_send_i = 0;
        bus.write_i    = 0;
    endtask

    task automatic clr_err();
        bus.err_clr_i = 1;
        tick();
        bus.err_clr_i = 0;
    endtask

    task automatic cmp_words(string name);
        chk({name, "_count"}, got.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < got.size(); i++) chk(name, got[i], exp_w[i]);
    endtask

    task automatic cmp_syms(string name);
        chk({name, "_count"}, sent.size(), exp_s.size());
        for (int i = 0; i < exp_s.size() && i < sent.size(); i++) chk(name, sent[i], exp_s[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit c, err0;
        logic [7:0] v;
        int kind;
        bit pat[4] = '{1, 0, 0, 1};
        tv = '{'{0, 8'h41, 1, 8'h41, 8'h00, 2'b00},
               '{0, 8'hB1, 2, 8'hB1, 8'hB1, 2'b00},
               '{1, 8'h10, 2, 8'hB1, 8'h10, 2'b00},
               '{1, 8'hB1, 0, 8'h00, 8'h00, 2'b01},
               '{0, 8'h00, 1, 8'h00, 8'h00, 2'b00},
               '{1, 8'h00, 2, 8'hB1, 8'h00, 2'b00},
               '{0, 8'hFF, 1, 8'hFF, 8'h00, 2'b00}};
        {bus.read_i, bus.write_i, bus.cmd_send_i, bus.err_clr_i} = '0;
        {bus.data_send_i, bus.cmd_i} = '0;
        bus.tx_ready_i = 1;
        uq = '{8'h77};
        feed();
        #12;
        chk("rst_read_o", bus.read_o, 0);
        chk("rst_rx_empty_o", bus.rx_empty_o, 1);
        chk("rst_cmd_rec_o", bus.cmd_rec_o, 0);
        chk("rst_data_rec_o", bus.data_rec_o, 0);
        chk("rst_write_o", bus.write_o, 0);
        chk("rst_data_send_o", bus.data_send_o, 0);
        chk("rst_tx_ready_o", bus.tx_ready_o, 1);
        chk("rst_err_o", bus.err_o, 0);
        uq.delete();
        feed();
        @(posedge clk); #1;
        rst_n = 1;

        // Decoding: plain, escaped ESC, command
        uq = '{8'h41, 8'hB1, 8'hB1, 8'hB1, 8'h05};
        feed();
        tap_auto = 1;
        got.delete();
        repeat (12) tick();
        exp_w = '{9'h041, 9'h0B1, 9'h105};
        cmp_words("rx_stream");
        chk("rx_stream_empty", bus.rx_empty_o, 1);
        chk("rx_stream_err", bus.err_o, 0);

        // Full queue stalls the UART pop
        tap_auto = 0;
        bus.read_i = 0;
        got.delete();
        uq = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        feed();
        repeat (10) tick();
        #1;
        chk("full_uart_left", uq.size(), 2);
        chk("full_read_o", bus.read_o, 0);
        chk("full_rx_empty_o", bus.rx_empty_o, 0);
        chk("full_head", bus.data_rec_o, 8'h10);
        tap_auto = 1;
        repeat (14) tick();
        exp_w = '{9'h010, 9'h020, 9'h030, 9'h040, 9'h050, 9'h060};
        cmp_words("full_order");
        chk("full_uart_drained", uq.size(), 0);

        // Encoder table
        for (int i = 0; i < 7; i++) begin
            sent.delete();
            tx_req(tv[i].cmd, 0, tv[i].v, tv[i].v);
            chk("tbl_ready_after_accept", bus.tx_ready_o, tv[i].n == 0);
            wait_idle();
            chk("tbl_nsyms", sent.size(), tv[i].n);
            if (tv[i].n > 0 && sent.size() > 0) chk("tbl_sym0", sent[0], tv[i].s0);
            if (tv[i].n > 1 && sent.size() > 1) chk("tbl_sym1", sent[1], tv[i].s1);
            chk("tbl_err", bus.err_o, tv[i].err);
            clr_err();
        end

        // Back-to-back requests and simultaneous request priority
        sent.delete();
        tx_req(0, 0, 8'h00, 8'hB1);
        tx_req(1, 0, 8'h10, 8'h00);
        tx_req(1, 1, 8'h22, 8'h33);
        wait_idle();
        exp_s = '{8'hB1, 8'hB1, 8'hB1, 8'h10, 8'hB1, 8'h22};
        cmp_syms("tx_seq");

        // Error flags: clear, set-wins, RX pop while empty
        tx_req(1, 0, ESC, 8'h00);
        chk("err_cmd_esc", bus.err_o, 2'b01);
        clr_err();
        chk("err_cleared", bus.err_o, 2'b00);
        bus.err_clr_i = 1;
        tx_req(1, 0, ESC, 8'h00);
        bus.err_clr_i = 0;
        chk("err_set_wins", bus.err_o, 2'b01);
        clr_err();
        tap_auto = 0;
        bus.read_i = 1;
        tick();
        bus.read_i = 0;
        chk("err_rx_pop_empty", bus.err_o, 2'b10);
        clr_err();

        // TX_READY_I gating
        sent.delete();
        tx_req(0, 0, 8'h00, ESC);
        for (int i = 0; i < 4; i++) begin
            bus.tx_ready_i = pat[i];
            tick();
            chk("gate_write_o", last_write, pat[i]);
        end
        chk("gate_ready_back", bus.tx_ready_o, 1);
        exp_s = '{8'hB1, 8'hB1};
        cmp_syms("gate_syms");

        // Randomized RX against the wire encoding
        got.delete();
        exp_w.delete();
        for (int i = 0; i < 40; i++) begin
            v = $urandom_range(0, 3) == 0 ? ESC : 8'($urandom);
            c = $urandom_range(0, 2) == 0 && v != ESC;
            exp_w.push_back({c, v});
            if (c) begin uq.push_back(ESC); uq.push_back(v); end
            else if (v == ESC) begin uq.push_back(ESC); uq.push_back(ESC); end
            else uq.push_back(v);
        end
        feed();
        tap_auto = 1;
        tap_rnd = 1;
        n = 0;
        while (got.size() < exp_w.size() && n < 2000) begin tick(); n++; end
        tap_rnd = 0;
        cmp_words("rand_rx");
        chk("rand_rx_err", bus.err_o, 0);

        // Randomized TX with random TX_READY_I
        sent.delete();
        exp_s.delete();
        err0 = 0;
        rdy_rnd = 1;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            v = $urandom_range(0, 3) == 0 ? ESC : 8'($urandom);
            if (kind == 0) begin
                exp_s.push_back(v);
                if (v == ESC) exp_s.push_back(ESC);
                tx_req(0, 0, 8'($urandom), v);
            end else begin
                if (v == ESC) err0 = 1;
                else begin exp_s.push_back(ESC); exp_s.push_back(v); end
                tx_req(1, kind == 2, v, 8'($urandom));
            end
        end
        wait_idle();
        rdy_rnd = 0;
        bus.tx_ready_i = 1;
        cmp_syms("rand_tx");
        chk("rand_tx_err", bus.err_o, {1'b0, err0});
        clr_err();

        // Reset with RX in an escape and TX holding a second symbol
        tap_auto = 0;
        bus.read_i = 0;
        uq = '{ESC};
        feed();
        tx_req(0, 0, 8'h00, ESC);
        tick();
        chk("mid_pre_write", bus.write_o, 1);
        rst_n = 0;
        #1;
        chk("mid_write_o", bus.write_o, 0);
        chk("mid_data_send_o", bus.data_send_o, 0);
        chk("mid_tx_ready_o", bus.tx_ready_o, 1);
        chk("mid_rx_empty_o", bus.rx_empty_o, 1);
        chk("mid_read_o", bus.read_o, 0);
        chk("mid_err_o", bus.err_o, 0);
        uq = '{8'h05};
        feed();
        #2;
        rst_n = 1;
        got.delete();
        tap_auto = 1;
        repeat (6) tick();
        exp_w = '{9'h005};
        cmp_words("mid_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
